// File: rtl/x32_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : x32_to_fixed_pipe
// Description : Two-stage pipelined integer to Q(INT_W).(FRAC_W) converter.
//               Per-beat signed/unsigned input and symmetric saturation.
//               Valid/ready streams on both sides, plus sticky saturation
//               statistics (flag and saturating event counter).
// Revision    : 1.0 - initial release
// ============================================================================
module x32_to_fixed_pipe #(
   parameter int IN_W   = 32,
   parameter int INT_W  = 16,
   parameter int FRAC_W = 48,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      sign_mask,
   input  logic [IN_W-1:0]           in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [INT_W+FRAC_W-1:0]   out_data,
   output logic                      out_sat,
   input  logic                      sat_clear,
   output logic                      sat_flag,
   output logic [CNT_W-1:0]          sat_count
);

   localparam int OUT_W = INT_W + FRAC_W;

   // Saturation limits are symmetric: the negative limit is -max, not the
   // most-negative code, so a saturated sign flip never overflows downstream.
   localparam logic [OUT_W-1:0] C_SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] C_SAT_MIN = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic              s1_valid_q,  s1_valid_d;
   logic              s1_sign_q,   s1_sign_d;
   logic [IN_W-1:0]   s1_mag_q,    s1_mag_d;
   logic              s1_ovf_q,    s1_ovf_d;

   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q,  out_data_d;
   logic              out_sat_q,   out_sat_d;

   logic              sat_flag_q,  sat_flag_d;
   logic [CNT_W-1:0]  sat_count_q, sat_count_d;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic              w_s2_load;
   logic              w_in_fire;
   logic              w_out_sat_fire;
   logic              w_sign;
   logic [IN_W-1:0]   w_mag;
   logic              w_ovf;
   logic [OUT_W-1:0]  w_ext;
   logic [OUT_W-1:0]  w_result;

   // Pipeline flow control: S2 takes a new value whenever it is empty or
   // being drained; S1 can accept whenever it is empty or moving into S2.
   always_comb begin
      w_s2_load      = !out_valid_q || out_ready;
      in_ready       = !s1_valid_q || w_s2_load;
      w_in_fire      = in_valid && in_ready;
      w_out_sat_fire = out_valid_q && out_ready && out_sat_q;
   end

   // Stage-1 arithmetic: sign extraction, magnitude and overflow detection.
   // Any magnitude bit at or above INT_W-1 cannot fit in the signed integer
   // field, which also catches the signed most-negative input.
   always_comb begin
      w_sign = sign_mask && in_data[IN_W-1];
      w_mag  = w_sign ? -in_data : in_data;
      w_ovf  = |w_mag[IN_W-1:INT_W-1];
   end

   // Stage-2 arithmetic: place the magnitude in the integer field, restore
   // the sign, or substitute the symmetric saturation limit.
   always_comb begin
      w_ext = OUT_W'(s1_mag_q) << FRAC_W;
      if (s1_ovf_q) begin
         w_result = s1_sign_q ? C_SAT_MIN : C_SAT_MAX;
      end else begin
         w_result = s1_sign_q ? -w_ext : w_ext;
      end
   end

   // Stage-1 next state: load on input handshake, empty when drained.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_mag_d   = s1_mag_q;
      s1_ovf_d   = s1_ovf_q;
      if (w_in_fire) begin
         s1_valid_d = 1'b1;
         s1_sign_d  = w_sign;
         s1_mag_d   = w_mag;
         s1_ovf_d   = w_ovf;
      end else if (w_s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage-2 next state: output register holds steady while stalled, and
   // only captures data when a real beat arrives from S1.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      if (w_s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = w_result;
            out_sat_d  = s1_ovf_q;
         end
      end
   end

   // Statistics next state: a saturated delivery in the same cycle as a
   // clear wins and restarts the count at one.
   always_comb begin
      sat_flag_d  = sat_flag_q;
      sat_count_d = sat_count_q;
      if (w_out_sat_fire && sat_clear) begin
         sat_flag_d  = 1'b1;
         sat_count_d = C_CNT_ONE;
      end else if (sat_clear) begin
         sat_flag_d  = 1'b0;
         sat_count_d = '0;
      end else if (w_out_sat_fire) begin
         sat_flag_d  = 1'b1;
         if (sat_count_q != C_CNT_MAX) begin
            sat_count_d = sat_count_q + C_CNT_ONE;
         end
      end
   end

   // Pipeline and statistics registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mag_q    <= '0;
         s1_ovf_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         sat_flag_q  <= 1'b0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_mag_q    <= s1_mag_d;
         s1_ovf_q    <= s1_ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         sat_flag_q  <= sat_flag_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign sat_flag  = sat_flag_q;
   assign sat_count = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_x32_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_x32_to_fixed_pipe
// Description : Directed self-checking bench for x32_to_fixed_pipe. A second
//               instance with a 2-bit counter runs in lockstep to exercise
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x32_to_fixed_pipe;

   localparam int IN_W   = 32;
   localparam int INT_W  = 16;
   localparam int FRAC_W = 48;
   localparam int OUT_W  = 64;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic              sign_mask;
   logic [IN_W-1:0]   in_data;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_sat;
   logic              sat_clear;
   logic              sat_flag;
   logic [CNT_W-1:0]  sat_count;

   logic              in_ready2;
   logic              out_valid2;
   logic [OUT_W-1:0]  out_data2;
   logic              out_sat2;
   logic              sat_flag2;
   logic [1:0]        sat_count2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   x32_to_fixed_pipe #(
      .IN_W(IN_W), .INT_W(INT_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .sign_mask(sign_mask), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat),
      .sat_clear(sat_clear), .sat_flag(sat_flag), .sat_count(sat_count)
   );

   x32_to_fixed_pipe #(
      .IN_W(IN_W), .INT_W(INT_W), .FRAC_W(FRAC_W), .CNT_W(2)
   ) dut2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready2),
      .sign_mask(sign_mask), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .out_sat(out_sat2),
      .sat_clear(sat_clear), .sat_flag(sat_flag2), .sat_count(sat_count2)
   );

   // Drive one beat into an empty pipeline with out_ready high, wait for it
   // to appear (bounded), optionally assert sat_clear on its delivery cycle.
   // lat = number of edges from the accepting edge's cycle to out_valid.
   task automatic send_beat(input logic sm, input logic [31:0] d, input logic clr,
                            output logic [63:0] od, output logic os, output int lat);
      int cyc;
      sign_mask = sm;
      in_data   = d;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      od  = out_data;
      os  = out_sat;
      lat = cyc;
      sat_clear = clr;
      @(posedge clk); #1;
      sat_clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; sign_mask = 1'b0; in_data = '0;
      out_ready = 1'b0; sat_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
      n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
      n_checks++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL reset_sat_count got %0d want 0", sat_count); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [63:0] od; logic os; int lat;
      send_beat(1'b1, 32'd5, 1'b0, od, os, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency got %0d want 2", lat); end
      n_checks++; if (od !== 64'h0005_0000_0000_0000) begin n_fail++; $display("FAIL basic_data got %h want 0005000000000000", od); end
      n_checks++; if (os !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b want 0", os); end
   endtask

   task automatic test_conversion();
      logic        vsm [12];
      logic [31:0] vin [12];
      logic [63:0] vexp[12];
      logic        vsat[12];
      logic [63:0] od; logic os; int lat;
      vsm  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vin  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_8000,
               32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
               32'h0000_0000, 32'h0000_7FFF, 32'hFFFF_8001, 32'h0000_7FFF};
      vexp = '{64'hFFFD_0000_0000_0000, 64'hFFFF_0000_0000_0000,
               64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
               64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF,
               64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_0000,
               64'h0000_0000_0000_0000, 64'h7FFF_0000_0000_0000,
               64'h8001_0000_0000_0000, 64'h7FFF_0000_0000_0000};
      vsat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         send_beat(vsm[i], vin[i], 1'b0, od, os, lat);
         n_checks++;
         if (od !== vexp[i] || os !== vsat[i] || lat !== 2) begin
            n_fail++;
            $display("FAIL conv[%0d] in=%h sm=%b got data=%h sat=%b lat=%0d want data=%h sat=%b lat=2",
                     i, vin[i], vsm[i], od, os, lat, vexp[i], vsat[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int recv = 0;
      logic        prev_stall = 1'b0;
      logic [63:0] prev_data  = '0;
      logic [63:0] exp_d;
      logic        exp_rdy;
      for (int c = 0; c < 40 && recv < 8; c++) begin
         sign_mask = 1'b1;
         in_valid  = (sent < 8);
         in_data   = 32'(sent + 1);
         out_ready = !(c >= 3 && c <= 6);
         #1;
         exp_rdy = !((sent - recv) == 2 && !out_ready);
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL b2b_in_ready cyc=%0d got %b want %b", c, in_ready, exp_rdy);
         end
         if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               n_fail++; $display("FAIL b2b_hold cyc=%0d got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, prev_data);
            end
         end
         if (out_valid && out_ready) begin
            exp_d = {16'(recv + 1), 48'h0};
            n_checks++;
            if (out_data !== exp_d || out_sat !== 1'b0) begin
               n_fail++; $display("FAIL b2b_data idx=%0d got %h sat=%b want %h sat=0", recv, out_data, out_sat, exp_d);
            end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++;
      if (recv !== 8 || sent !== 8) begin
         n_fail++; $display("FAIL b2b_count got sent=%0d recv=%0d want 8/8", sent, recv);
      end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_stats();
      logic [63:0] od; logic os; int lat;
      reset = 1'b1; #2 reset = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) send_beat(1'b1, 32'h0000_8000, 1'b0, od, os, lat);
      n_checks++; if (sat_count !== 16'd5 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL stats_five got cnt=%0d flag=%b want 5/1", sat_count, sat_flag); end
      n_checks++; if (sat_count2 !== 2'd3 || sat_flag2 !== 1'b1) begin n_fail++; $display("FAIL stats_cnt2_five got cnt=%0d flag=%b want 3/1", sat_count2, sat_flag2); end
      send_beat(1'b1, 32'hFFFF_8000, 1'b1, od, os, lat);
      n_checks++; if (sat_count !== 16'd1 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL stats_clear_hs got cnt=%0d flag=%b want 1/1", sat_count, sat_flag); end
      n_checks++; if (sat_count2 !== 2'd1) begin n_fail++; $display("FAIL stats_cnt2_clear_hs got cnt=%0d want 1", sat_count2); end
      sat_clear = 1'b1;
      @(posedge clk); #1;
      sat_clear = 1'b0;
      n_checks++; if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL stats_clear got cnt=%0d flag=%b want 0/0", sat_count, sat_flag); end
      send_beat(1'b1, 32'd5, 1'b0, od, os, lat);
      n_checks++; if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL stats_nosat got cnt=%0d flag=%b want 0/0", sat_count, sat_flag); end
      for (int i = 0; i < 6; i++) send_beat(1'b0, 32'hFFFF_FFFF, 1'b0, od, os, lat);
      n_checks++; if (sat_count !== 16'd6) begin n_fail++; $display("FAIL stats_six got cnt=%0d want 6", sat_count); end
      n_checks++; if (sat_count2 !== 2'd3 || sat_flag2 !== 1'b1) begin n_fail++; $display("FAIL stats_cnt2_six got cnt=%0d flag=%b want 3/1", sat_count2, sat_flag2); end
   endtask

   task automatic test_reset_midstream();
      sign_mask = 1'b1;
      in_data   = 32'h0000_8000;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_prefill got v=%b rdy=%b want 1/0", out_valid, in_ready); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
      n_checks++; if (sat_count !== 16'd0 || sat_flag !== 1'b0 || out_sat !== 1'b0) begin n_fail++; $display("FAIL mid_stats got cnt=%0d flag=%b sat=%b want 0/0/0", sat_count, sat_flag, out_sat); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_output cyc=%0d got %b want 0", i, out_valid); end
      end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_conversion();
      test_back_to_back();
      test_stats();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
